shifter_pipe: RTL and testbench

Pipelined, parametrised barrel shifter for the processor's execute stage: the successor to the fixed-distance, single-mode 32-bit shift stages. It takes an operand, shift amount, mode and tag through a valid/ready handshake and returns the result a fixed number of cycles later. It supports logical left, logical right, arithmetic right and rotate left. Pipeline depth is set at elaboration, and the whole pipeline stalls cleanly under backpressure.

---
 rtl/shifter_pkg.sv | 16 +
 rtl/shift_stage.sv | 28 ++
 rtl/shifter_pipe.sv | 136 +++++++++++++
 tb/tb_shifter_pipe.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Op encoding and slice-count arithmetic used by shifter_pipe.
package shifter_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROL = 2'b11
    } shift_op_e;

    function automatic int num_slices(input int shamt_w, input int reg_every);
        return (shamt_w + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One log-shift step: shifts by DIST when enabled, for all four ops.
// Purely combinational; SRA relies on bit WIDTH-1 still holding the sign.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  shift_op_e        op_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        if (en_i) begin
            unique case (op_i)
                SHIFT_SLL: data_o = data_i << DIST;
                SHIFT_SRL: data_o = data_i >> DIST;
                SHIFT_SRA: data_o = $signed(data_i) >>> DIST;
                SHIFT_ROL: data_o = (data_i << DIST) | (data_i >> (WIDTH - DIST));
                default:   data_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter with valid/ready handshake and flush.
// Register slices sit after every REG_EVERY log-shift stages.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SHAMT_W   = $clog2(WIDTH),
    parameter int REG_EVERY = 1,
    parameter int TAG_W     = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int L = num_slices(SHAMT_W, REG_EVERY);

    logic [L-1:0] v_q;
    logic [L-1:0] go;
    logic [L-1:0] ld;
    logic [L:0]   vin;
    logic         unused_vin;

    assign vin        = {v_q, in_valid};
    assign unused_vin = vin[L];

    // A slice can move when any slice at or after it has a hole.
    always_comb begin
        go = '0;
        ld = '0;
        for (int j = 0; j < L; j++) begin
            go[j] = out_ready;
            for (int i = j; i < L; i++) begin
                go[j] = go[j] | ~v_q[i];
            end
            ld[j] = go[j] & vin[j] & ~flush;
        end
    end

    assign in_ready  = ~flush & go[0];
    assign out_valid = v_q[L-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= '0;
        end else if (flush) begin
            v_q <= '0;
        end else begin
            for (int j = 0; j < L; j++) begin
                if (go[j]) begin
                    v_q[j] <= vin[j];
                end
            end
        end
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stg
        logic [WIDTH-1:0]   data_s;
        logic [WIDTH-1:0]   res;
        shift_op_e          op_s;
        logic [SHAMT_W-1:0] shamt_s;
        logic [TAG_W-1:0]   tag_s;
        logic               unused_shamt;

        assign unused_shamt = ^shamt_s;

        if (k == 0) begin : g_src
            assign data_s  = in_data;
            assign op_s    = shift_op_e'(in_op);
            assign shamt_s = in_shamt;
            assign tag_s   = in_tag;
        end else if (k % REG_EVERY == 0) begin : g_src
            assign data_s  = g_stg[k-1].g_reg.data_q;
            assign op_s    = g_stg[k-1].g_reg.op_q;
            assign shamt_s = g_stg[k-1].g_reg.shamt_q;
            assign tag_s   = g_stg[k-1].g_reg.tag_q;
        end else begin : g_src
            assign data_s  = g_stg[k-1].res;
            assign op_s    = g_stg[k-1].op_s;
            assign shamt_s = g_stg[k-1].shamt_s;
            assign tag_s   = g_stg[k-1].tag_s;
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (2 ** k)
        ) u_stage (
            .data_i (data_s),
            .en_i   (shamt_s[k]),
            .op_i   (op_s),
            .data_o (res)
        );

        if (((k + 1) % REG_EVERY == 0) || (k == SHAMT_W - 1)) begin : g_reg
            localparam int J = k / REG_EVERY;

            logic [WIDTH-1:0]   data_q;
            shift_op_e          op_q;
            logic [SHAMT_W-1:0] shamt_q;
            logic [TAG_W-1:0]   tag_q;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    data_q  <= '0;
                    op_q    <= SHIFT_SLL;
                    shamt_q <= '0;
                    tag_q   <= '0;
                end else if (ld[J]) begin
                    data_q  <= res;
                    op_q    <= op_s;
                    shamt_q <= shamt_s;
                    tag_q   <= tag_s;
                end
            end

            if (k == SHAMT_W - 1) begin : g_tail
                logic unused_tail;
                assign unused_tail = ^{op_q, shamt_q};
            end
        end
    end

    assign out_data = g_stg[SHAMT_W-1].g_reg.data_q;
    assign out_tag  = g_stg[SHAMT_W-1].g_reg.tag_q;

endmodule

// File: tb/tb_shifter_pipe.sv
// Testbench for shifter_pipe: directed vectors, handshake corners,
// and random traffic against an arithmetic reference model.
module tb_shifter_pipe;
    import shifter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_shamt, in_tag, out_tag;
    logic [1:0]  in_op;

    logic        a_valid, a_ready, a_ovalid, a_oready;
    logic [31:0] a_data, a_odata;
    logic [4:0]  a_shamt, a_tag, a_otag;
    logic [1:0]  a_op;

    logic        w_valid, w_ready, w_ovalid, w_oready;
    logic [15:0] w_data, w_odata;
    logic [3:0]  w_shamt;
    logic [4:0]  w_tag, w_otag;
    logic [1:0]  w_op;
    logic        aux_flush;

    always #5 clk = ~clk;

    shifter_pipe dut (
        .clock(clk), .reset_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    shifter_pipe #(.REG_EVERY(5)) dut_r5 (
        .clock(clk), .reset_n(rst_n), .flush(aux_flush),
        .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
        .in_shamt(a_shamt), .in_op(a_op), .in_tag(a_tag),
        .out_valid(a_ovalid), .out_ready(a_oready),
        .out_data(a_odata), .out_tag(a_otag)
    );

    shifter_pipe #(.WIDTH(16), .REG_EVERY(2)) dut_w16 (
        .clock(clk), .reset_n(rst_n), .flush(aux_flush),
        .in_valid(w_valid), .in_ready(w_ready), .in_data(w_data),
        .in_shamt(w_shamt), .in_op(w_op), .in_tag(w_tag),
        .out_valid(w_ovalid), .out_ready(w_oready),
        .out_data(w_odata), .out_tag(w_otag)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic on a w-bit value.
    function automatic logic [31:0] ref_shift(input int w, input logic [31:0] d,
                                              input int s, input logic [1:0] op);
        logic [63:0] m, x, r;
        m = (64'd1 << w) - 64'd1;
        x = {32'd0, d} & m;
        case (op)
            2'd0:    r = (x << s) & m;
            2'd1:    r = x >> s;
            2'd2:    r = (x >> s) | (x[w-1] ? (m & ~(m >> s)) : 64'd0);
            default: r = ((x << s) | (x >> (w - s))) & m;
        endcase
        return r[31:0];
    endfunction

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } exp_t;

    exp_t        q[$];
    logic        hold_pend = 1'b0;
    logic [31:0] hold_data;
    logic [4:0]  hold_tag;

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n || flush) begin
            q.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("stall_hold_data", out_data, hold_data);
                check("stall_hold_tag", out_tag, hold_tag);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_unexpected: got data %0h, required no output", out_data);
                end else begin
                    e = q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_tag", out_tag, e.tag);
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            hold_tag  = out_tag;
            if (in_valid && in_ready)
                q.push_back('{ref_shift(32, in_data, int'(in_shamt), in_op), in_tag});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [1:0]  op;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[16];

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int          lat, acc, cnt, cyc;
        int          rec_t[4];
        logic [31:0] rec_d[4];
        logic [31:0] b2b_exp[4];
        logic [31:0] held, sd;
        logic [4:0]  ss, st;
        logic [1:0]  so;

        vt[0]  = '{32'h8000_0001, 5'd4,  2'd2, 5'd7,  32'hF800_0000};
        vt[1]  = '{32'h8000_0001, 5'd1,  2'd0, 5'd1,  32'h0000_0002};
        vt[2]  = '{32'h8000_0001, 5'd1,  2'd1, 5'd2,  32'h4000_0000};
        vt[3]  = '{32'h8000_0001, 5'd1,  2'd2, 5'd3,  32'hC000_0000};
        vt[4]  = '{32'h8000_0001, 5'd1,  2'd3, 5'd4,  32'h0000_0003};
        vt[5]  = '{32'h0000_0001, 5'd31, 2'd0, 5'd5,  32'h8000_0000};
        vt[6]  = '{32'h8000_0000, 5'd31, 2'd3, 5'd6,  32'h4000_0000};
        vt[7]  = '{32'h8000_0000, 5'd31, 2'd2, 5'd8,  32'hFFFF_FFFF};
        vt[8]  = '{32'hDEAD_BEEF, 5'd0,  2'd0, 5'd9,  32'hDEAD_BEEF};
        vt[9]  = '{32'hDEAD_BEEF, 5'd0,  2'd1, 5'd10, 32'hDEAD_BEEF};
        vt[10] = '{32'hDEAD_BEEF, 5'd0,  2'd2, 5'd11, 32'hDEAD_BEEF};
        vt[11] = '{32'hDEAD_BEEF, 5'd0,  2'd3, 5'd12, 32'hDEAD_BEEF};
        vt[12] = '{32'h1234_5678, 5'd8,  2'd3, 5'd13, 32'h3456_7812};
        vt[13] = '{32'h1234_5678, 5'd31, 2'd1, 5'd14, 32'h0000_0000};
        vt[14] = '{32'h7FFF_FFFF, 5'd31, 2'd2, 5'd15, 32'h0000_0000};
        vt[15] = '{32'hF000_0000, 5'd4,  2'd1, 5'd16, 32'h0F00_0000};

        b2b_exp[0] = 32'h0000_0002;
        b2b_exp[1] = 32'h4000_0000;
        b2b_exp[2] = 32'hC000_0000;
        b2b_exp[3] = 32'h0000_0003;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
        aux_flush = 1'b0;
        a_valid = 1'b0; a_data = '0; a_shamt = '0; a_op = '0; a_tag = '0; a_oready = 1'b1;
        w_valid = 1'b0; w_data = '0; w_shamt = '0; w_op = '0; w_tag = '0; w_oready = 1'b1;

        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        tick; tick;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        tick;

        // Directed vectors, one at a time.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = vt[i].data; in_shamt = vt[i].shamt;
            in_op = vt[i].op; in_tag = vt[i].tag;
            tick;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                tick;
                lat++;
            end
            check("vec_latency", lat, 5);
            check("vec_data", out_data, vt[i].exp);
            check("vec_tag", out_tag, vt[i].tag);
        end

        // Back-to-back, results on consecutive cycles.
        cnt = 0;
        for (int t = 0; t < 14; t++) begin
            if (t < 4) begin
                in_valid = 1'b1; in_data = 32'h8000_0001; in_shamt = 5'd1;
                in_op = 2'(t); in_tag = 5'(20 + t);
            end else begin
                in_valid = 1'b0;
            end
            tick;
            if (out_valid && cnt < 4) begin
                rec_t[cnt] = t;
                rec_d[cnt] = out_data;
                cnt++;
            end
        end
        check("b2b_count", cnt, 4);
        for (int k = 0; k < 4; k++) begin
            check("b2b_data", rec_d[k], b2b_exp[k]);
            check("b2b_cycle", rec_t[k], 4 + k);
        end

        // Backpressure: fill, hold, same-edge accept/consume, drain.
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = $urandom; in_shamt = 5'($urandom);
            in_op = 2'($urandom); in_tag = 5'(i);
            #1;
            if (in_ready) acc++;
            tick;
        end
        in_valid = 1'b0;
        #1;
        check("bp_accepted", acc, 5);
        check("bp_in_ready_full", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        held = out_data;
        tick; tick; tick;
        check("bp_hold", out_data, held);
        in_valid = 1'b1; in_data = 32'h0F0F_1234; in_shamt = 5'd3;
        in_op = 2'd3; in_tag = 5'd30; out_ready = 1'b1;
        #1;
        check("bp_ready_same_cycle", in_ready, 1);
        tick;
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("bp_occupancy_full", in_ready, 0);
        out_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) cnt++;
            tick;
        end
        check("bp_drain_count", cnt, 5);
        check("bp_drained", q.size(), 0);

        // Flush with three in flight and a competing request.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'h1111_0000 + i; in_shamt = 5'd2;
            in_op = 2'd0; in_tag = 5'(i);
            tick;
        end
        flush = 1'b1; in_data = 32'hCAFE_0000;
        #1;
        check("flush_no_accept", in_ready, 0);
        tick;
        flush = 1'b0; in_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) cnt++;
            tick;
        end
        check("flush_no_output", cnt, 0);

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 32'hA5A5_A5A5; in_shamt = 5'd0;
            in_op = 2'd0; in_tag = 5'd9;
            tick;
        end
        in_valid = 1'b0;
        #1;
        check("rstp_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rstp_out_valid", out_valid, 0);
        check("rstp_out_data", out_data, 0);
        check("rstp_out_tag", out_tag, 0);
        tick; tick;
        rst_n = 1'b1; out_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) cnt++;
            tick;
        end
        check("rstp_no_stale", cnt, 0);

        // Random traffic against the reference model.
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            in_valid = ($urandom % 4) != 0;
            in_data = $urandom; in_shamt = 5'($urandom);
            in_op = 2'($urandom); in_tag = 5'($urandom);
            out_ready = ($urandom % 4) != 0;
            #1;
            if (in_valid && in_ready) acc++;
            tick;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) tick;
        check("rand_accepted", acc, 10000);
        check("rand_drained", q.size(), 0);

        // REG_EVERY=5 build: single slice.
        for (int i = 0; i < 20; i++) begin
            sd = $urandom; ss = 5'($urandom); so = 2'($urandom); st = 5'($urandom);
            if (i == 0) ss = 5'd0;
            a_valid = 1'b1; a_data = sd; a_shamt = ss; a_op = so; a_tag = st;
            tick;
            a_valid = 1'b0;
            lat = 1;
            while (!a_ovalid && lat < 20) begin
                tick;
                lat++;
            end
            check("r5_latency", lat, 1);
            check("r5_data", a_odata, ref_shift(32, sd, int'(ss), so));
            check("r5_tag", a_otag, st);
        end

        // WIDTH=16, REG_EVERY=2 build: two slices.
        for (int i = 0; i < 20; i++) begin
            sd = {16'd0, 16'($urandom)}; ss = 5'($urandom % 16);
            so = 2'($urandom); st = 5'($urandom);
            if (i == 0) begin
                sd = 32'h0000_8001; ss = 5'd15; so = 2'd2;
            end
            w_valid = 1'b1; w_data = sd[15:0]; w_shamt = ss[3:0]; w_op = so; w_tag = st;
            tick;
            w_valid = 1'b0;
            lat = 1;
            while (!w_ovalid && lat < 20) begin
                tick;
                lat++;
            end
            check("w16_latency", lat, 2);
            check("w16_data", w_odata, ref_shift(16, sd, int'(ss), so));
            check("w16_tag", w_otag, st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
